seven_seg_mux_scanner: RTL

- Parametrised multiplexed seven-segment driver for NUM_DIGITS common-anode digits.
- Owns the scan prescaler, digit index counter and hex-to-segment decode.
- Adds per-digit enable, decimal points, leading-zero suppression and PWM brightness.
- Sits between display data registers and the board anode/segment pins; all outputs are active-low.

---
 rtl/seven_seg_mux_scanner.sv | 134 +++++++++++++
 1 files changed

// File: rtl/seven_seg_mux_scanner.sv
`default_nettype none
// ============================================================================
// Module   : seven_seg_mux_scanner
// Brief    : Multiplexed common-anode seven-segment scanner with PWM
//            brightness, per-digit enable, decimal points and leading-zero
//            blanking. All pin outputs are active-low and registered.
// Revision : 1.0  initial release
// ============================================================================
module seven_seg_mux_scanner #(
    parameter  int NUM_DIGITS = 4,
    parameter  int SCAN_LOG2  = 16,
    parameter  int BRIGHT_W   = 3,
    localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    lz_blank,
    input  logic [BRIGHT_W-1:0]     brightness,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic [6:0]              seg,
    output logic                    dp_n,
    output logic [IDX_W-1:0]        scan_idx
);

    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NUM_DIGITS - 1);
    localparam logic [6:0]       c_seg_off  = 7'h7F;

    logic [SCAN_LOG2-1:0]  r_pcnt;
    logic [IDX_W-1:0]      r_idx;
    logic [NUM_DIGITS-1:0] r_anode;
    logic [6:0]            r_seg;
    logic                  r_dp_n;

    logic [NUM_DIGITS-1:0] w_supp;
    logic                  w_run_zero;
    logic [3:0]            w_val;
    logic                  w_dp;
    logic                  w_en;
    logic                  w_sup_sel;
    logic                  w_pwm_on;
    logic                  w_lit;
    logic [NUM_DIGITS-1:0] w_anode;
    logic [6:0]            w_seg;
    logic                  w_dp_n;

    function automatic logic [6:0] f_hex_to_seg(input logic [3:0] v);
        case (v)
            4'h0: f_hex_to_seg = 7'h40;
            4'h1: f_hex_to_seg = 7'h79;
            4'h2: f_hex_to_seg = 7'h24;
            4'h3: f_hex_to_seg = 7'h30;
            4'h4: f_hex_to_seg = 7'h19;
            4'h5: f_hex_to_seg = 7'h12;
            4'h6: f_hex_to_seg = 7'h02;
            4'h7: f_hex_to_seg = 7'h78;
            4'h8: f_hex_to_seg = 7'h00;
            4'h9: f_hex_to_seg = 7'h10;
            4'hA: f_hex_to_seg = 7'h08;
            4'hB: f_hex_to_seg = 7'h03;
            4'hC: f_hex_to_seg = 7'h46;
            4'hD: f_hex_to_seg = 7'h21;
            4'hE: f_hex_to_seg = 7'h06;
            default: f_hex_to_seg = 7'h0E;
        endcase
    endfunction

    // A digit is blank-able when it and every more-significant digit is a
    // zero with no decimal point; the rightmost digit always shows.
    always_comb begin
        w_run_zero = 1'b1;
        w_supp     = '0;
        for (int j = NUM_DIGITS - 1; j >= 0; j--) begin
            w_run_zero = w_run_zero & (digits[4*j +: 4] == 4'h0) & ~dp[j];
            w_supp[j]  = (j != 0) & w_run_zero;
        end
    end

    always_comb begin
        w_val     = 4'h0;
        w_dp      = 1'b0;
        w_en      = 1'b0;
        w_sup_sel = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_val     = digits[4*i +: 4];
                w_dp      = dp[i];
                w_en      = digit_en[i];
                w_sup_sel = w_supp[i];
            end
        end
    end

    assign w_pwm_on = (&brightness) || (r_pcnt[SCAN_LOG2-1 -: BRIGHT_W] < brightness);
    assign w_lit    = w_en && !(lz_blank && w_sup_sel) && w_pwm_on;

    always_comb begin
        w_anode = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_lit && (r_idx == IDX_W'(i))) begin
                w_anode[i] = 1'b0;
            end
        end
        w_seg  = w_lit ? f_hex_to_seg(w_val) : c_seg_off;
        w_dp_n = w_lit ? ~w_dp : 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pcnt  <= '0;
            r_idx   <= '0;
            r_anode <= '1;
            r_seg   <= c_seg_off;
            r_dp_n  <= 1'b1;
        end else begin
            r_pcnt <= r_pcnt + 1'b1;
            if (&r_pcnt) begin
                r_idx <= (r_idx == c_last_idx) ? '0 : r_idx + 1'b1;
            end
            r_anode <= w_anode;
            r_seg   <= w_seg;
            r_dp_n  <= w_dp_n;
        end
    end

    assign anode    = r_anode;
    assign seg      = r_seg;
    assign dp_n     = r_dp_n;
    assign scan_idx = r_idx;

endmodule
`default_nettype wire
